// File: rtl/packet_buffer_pkg.sv
// Shared definitions for the lane packet path.
// Contents:
//   assembler_state_e    - states of the stream assembler FSM
//   MAX_ETH_FRAME_LENGTH - default per-packet truncation limit in bytes
//   keep_from_count      - contiguous byte-enable mask for n valid bytes
package packet_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GATHER = 2'd1,
        DRAIN  = 2'd2
    } assembler_state_e;

    localparam int MAX_ETH_FRAME_LENGTH = 1518;

    // n = 0..64; the 64-bit wrap of 1<<64 yields all ones after the subtract.
    function automatic logic [63:0] keep_from_count(input int unsigned n);
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Picks the lowest-index requester at or after ptr, wrapping around.
// Ports:
//   req       - request vector, one bit per lane
//   ptr       - lane index with highest priority this round
//   grant     - one-hot grant, zero when nothing requests
//   grant_idx - binary index of the granted lane (0 when no grant)
module rr_arbiter #(
    parameter int NUM_LANES = 8,
    parameter int PTR_W     = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [PTR_W-1:0]     grant_idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    // NUM_LANES is a power of two, so ptr + i wraps naturally in PTR_W bits.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            cand = ptr + PTR_W'(i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/packet_stream_assembler.sv
// Reassembles per-lane byte streams into one AXI4-Stream master, one packet
// at a time, lanes served round-robin at packet granularity. Bytes are
// packed little-endian, tkeep is contiguous from bit 0, tlast marks the
// packet end. Packets longer than MAX_PACKET_BYTES are cut at the limit and
// the remainder is consumed from the lane and discarded.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   lane_tdata_i/tvalid_i/
//   lane_tlast_i             - per-lane byte streams (lane n at bits n*LANE_WIDTH)
//   lane_tready_o            - per-lane ready, one-hot or zero
//   tdata_o/tkeep_o/tvalid_o/
//   tlast_o, tready_i        - AXI4-Stream master
//   trunc_o                  - one-cycle pulse alongside a truncated packet's last word
//   pkt_count_o              - wrapping count of packets accepted downstream
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arbitrate among valid lanes, latch grant, clear byte count
// GATHER | take bytes from granted lane into packer, commit words
// DRAIN  | packet truncated; swallow granted lane's bytes until tlast
module packet_stream_assembler
    import packet_buffer_pkg::*;
#(
    parameter int AXI_WIDTH        = 64,
    parameter int LANE_WIDTH       = 8,
    parameter int NUM_LANES        = 8,
    parameter int MAX_PACKET_BYTES = MAX_ETH_FRAME_LENGTH
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [LANE_WIDTH*NUM_LANES-1:0] lane_tdata_i,
    input  logic [NUM_LANES-1:0]            lane_tvalid_i,
    input  logic [NUM_LANES-1:0]            lane_tlast_i,
    output logic [NUM_LANES-1:0]            lane_tready_o,
    output logic [AXI_WIDTH-1:0]            tdata_o,
    output logic [AXI_WIDTH/8-1:0]          tkeep_o,
    output logic                            tvalid_o,
    input  logic                            tready_i,
    output logic                            tlast_o,
    output logic                            trunc_o,
    output logic [31:0]                     pkt_count_o
);

    localparam int SLOTS  = AXI_WIDTH / LANE_WIDTH;
    localparam int KEEP_W = AXI_WIDTH / 8;
    localparam int IDX_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int PTR_W  = $clog2(NUM_LANES);
    localparam int CNT_W  = $clog2(MAX_PACKET_BYTES + 1);

    assembler_state_e     state;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     byte_cnt;
    logic [AXI_WIDTH-1:0] pack_data;

    logic [NUM_LANES-1:0] arb_grant;
    logic [PTR_W-1:0]     arb_idx;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .PTR_W     (PTR_W)
    ) u_rr_arbiter (
        .req       (lane_tvalid_i),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    logic [LANE_WIDTH-1:0] cur_data;
    logic                  cur_valid;
    logic                  cur_last;
    logic                  out_free;
    logic                  word_full;
    logic                  at_limit;
    logic                  needs_commit;
    logic                  gather_rdy;
    logic                  take;
    logic [AXI_WIDTH-1:0]  merged;
    logic [KEEP_W-1:0]     keep_next;

    assign cur_data  = lane_tdata_i[grant_idx*LANE_WIDTH +: LANE_WIDTH];
    assign cur_valid = lane_tvalid_i[grant_idx];
    assign cur_last  = lane_tlast_i[grant_idx];

    // Output register can take a word now: empty, or being emptied this cycle.
    assign out_free  = !tvalid_o || tready_i;

    // The byte that completes a word, ends a packet or hits the limit is
    // committed together with the packer contents in the same edge, so the
    // packer never sits full; it only stalls when that commit has nowhere to go.
    assign word_full    = (idx == IDX_W'(SLOTS - 1));
    assign at_limit     = (byte_cnt == CNT_W'(MAX_PACKET_BYTES - 1));
    assign needs_commit = cur_last || word_full || at_limit;
    assign gather_rdy   = (state == GATHER) && (!needs_commit || out_free);
    assign take         = gather_rdy && cur_valid;

    assign merged    = pack_data | (AXI_WIDTH'(cur_data) << (32'(idx) * LANE_WIDTH));
    assign keep_next = KEEP_W'(keep_from_count(32'(idx) + 32'd1));

    assign lane_tready_o = (gather_rdy || state == DRAIN)
                           ? (NUM_LANES'(1) << grant_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            grant_idx   <= '0;
            rr_ptr      <= '0;
            idx         <= '0;
            byte_cnt    <= '0;
            pack_data   <= '0;
            tdata_o     <= '0;
            tkeep_o     <= '0;
            tvalid_o    <= 1'b0;
            tlast_o     <= 1'b0;
            trunc_o     <= 1'b0;
            pkt_count_o <= '0;
        end else begin
            trunc_o <= 1'b0;

            if (tvalid_o && tready_i) begin
                tvalid_o <= 1'b0;
                if (tlast_o) begin
                    pkt_count_o <= pkt_count_o + 32'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (|arb_grant) begin
                        grant_idx <= arb_idx;
                        byte_cnt  <= '0;
                        idx       <= '0;
                        pack_data <= '0;
                        state     <= GATHER;
                    end
                end

                GATHER: begin
                    if (take) begin
                        if (byte_cnt != CNT_W'(MAX_PACKET_BYTES)) begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                        if (needs_commit) begin
                            tvalid_o  <= 1'b1;
                            tdata_o   <= merged;
                            tkeep_o   <= keep_next;
                            tlast_o   <= cur_last || at_limit;
                            pack_data <= '0;
                            idx       <= '0;
                            if (cur_last) begin
                                rr_ptr <= grant_idx + PTR_W'(1);
                                state  <= IDLE;
                            end else if (at_limit) begin
                                trunc_o <= 1'b1;
                                state   <= DRAIN;
                            end
                        end else begin
                            pack_data <= merged;
                            idx       <= idx + IDX_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (cur_valid && cur_last) begin
                        rr_ptr <= grant_idx + PTR_W'(1);
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_stream_assembler.sv
// Self-checking bench for packet_stream_assembler. Lane drivers replay
// per-lane byte queues; a packet-level model predicts the egress word
// stream, the lane completion order, truncation and packet counts.
module tb_packet_stream_assembler;

    localparam int NL   = 8;
    localparam int MAXB = 70;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NL*8-1:0] lane_tdata = '0;
    logic [NL-1:0]   lane_tvalid = '0;
    logic [NL-1:0]   lane_tlast = '0;
    logic [NL-1:0]   lane_tready;
    logic [63:0]     tdata;
    logic [7:0]      tkeep;
    logic            tvalid;
    logic            tready = 1'b0;
    logic            tlast;
    logic            trunc;
    logic [31:0]     pkt_count;

    packet_stream_assembler #(
        .AXI_WIDTH        (64),
        .LANE_WIDTH       (8),
        .NUM_LANES        (NL),
        .MAX_PACKET_BYTES (MAXB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .lane_tdata_i  (lane_tdata),
        .lane_tvalid_i (lane_tvalid),
        .lane_tlast_i  (lane_tlast),
        .lane_tready_o (lane_tready),
        .tdata_o       (tdata),
        .tkeep_o       (tkeep),
        .tvalid_o      (tvalid),
        .tready_i      (tready),
        .tlast_o       (tlast),
        .trunc_o       (trunc),
        .pkt_count_o   (pkt_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver side
    logic [7:0] lane_bytes [NL][$];
    bit         lane_lastf [NL][$];
    // model side
    logic [7:0] model_bytes[NL][$];
    int         model_lens [NL][$];
    // predictions
    logic [63:0] exp_d[$];
    logic [7:0]  exp_k[$];
    bit          exp_l[$];
    int          exp_order[$];
    int          rr_model = 0;
    int          exp_pkts = 0;
    int          exp_trunc = 0;
    // observations
    int          trunc_seen = 0;
    int          acc_cnt = 0;
    int          onehot_viol = 0;
    int          stall_viol = 0;
    logic [63:0] last_d = '0;
    bit          prev_stall = 0;
    logic [63:0] snap_d;
    logic [7:0]  snap_k;
    logic        snap_l;
    int          tready_mode = 0;  // 0: always ready, 1: random, 2: held low
    bit          gap_mode = 0;

    task automatic add_packet(input int l, input int len, input bit seq, input bit modeled);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = seq ? 8'(i + 1) : 8'($urandom);
            lane_bytes[l].push_back(b);
            lane_lastf[l].push_back(i == len - 1);
            if (modeled) model_bytes[l].push_back(b);
        end
        if (modeled) model_lens[l].push_back(len);
    endtask

    // Serve queued packets round-robin and turn each into expected words.
    task automatic model_schedule();
        int l, len, n, cnt;
        bit any;
        logic [7:0]  pk[$];
        logic [63:0] d;
        forever begin
            any = 0;
            l = 0;
            for (int i = 0; i < NL; i++) begin
                if (!any && model_lens[(rr_model + i) % NL].size() > 0) begin
                    any = 1;
                    l = (rr_model + i) % NL;
                end
            end
            if (!any) break;
            len = model_lens[l].pop_front();
            pk.delete();
            for (int i = 0; i < len; i++) pk.push_back(model_bytes[l].pop_front());
            n = (len > MAXB) ? MAXB : len;
            for (int w = 0; w < n; w += 8) begin
                cnt = (n - w > 8) ? 8 : n - w;
                d = '0;
                for (int j = 0; j < cnt; j++) d[j*8 +: 8] = pk[w + j];
                exp_d.push_back(d);
                exp_k.push_back(8'((9'd1 << cnt) - 9'd1));
                exp_l.push_back(w + cnt == n);
            end
            exp_order.push_back(l);
            exp_pkts++;
            if (len > MAXB) exp_trunc++;
            rr_model = (l + 1) % NL;
        end
    endtask

    task automatic tick();
        bit v;
        @(negedge clk);
        case (tready_mode)
            0:       tready = 1'b1;
            1:       tready = ($urandom_range(0, 3) != 0);
            default: tready = 1'b0;
        endcase
        for (int l = 0; l < NL; l++) begin
            v = (lane_bytes[l].size() > 0) && !(gap_mode && $urandom_range(0, 3) == 0);
            lane_tvalid[l]        = v;
            lane_tdata[l*8 +: 8]  = v ? lane_bytes[l][0] : 8'h00;
            lane_tlast[l]         = v ? lane_lastf[l][0] : 1'b0;
        end
        #1;
        if ($countones(lane_tready) > 1) onehot_viol++;
        if (prev_stall && (tdata !== snap_d || tkeep !== snap_k || tlast !== snap_l || !tvalid))
            stall_viol++;
        prev_stall = tvalid && !tready;
        snap_d = tdata; snap_k = tkeep; snap_l = tlast;
        for (int l = 0; l < NL; l++) begin
            if (lane_tvalid[l] && lane_tready[l]) begin
                acc_cnt++;
                if (lane_tlast[l]) begin
                    if (exp_order.size() > 0) check("grant_order", 64'(l), 64'(exp_order.pop_front()));
                    else check("unexpected_packet_end", 64'(l), 64'hFFFF);
                end
                void'(lane_bytes[l].pop_front());
                void'(lane_lastf[l].pop_front());
            end
        end
        if (tvalid && tready) begin
            last_d = tdata;
            if (exp_d.size() > 0) begin
                check("word_data", tdata, exp_d.pop_front());
                check("word_keep", 64'(tkeep), 64'(exp_k.pop_front()));
                check("word_last", 64'(tlast), 64'(exp_l.pop_front()));
            end else begin
                check("unexpected_word", 64'(tdata), 64'hDEAD_0000_0000_DEAD);
            end
        end
        if (trunc) trunc_seen++;
    endtask

    function automatic int pending_bytes();
        int p = 0;
        for (int l = 0; l < NL; l++) p += lane_bytes[l].size();
        return p;
    endfunction

    task automatic run_until_done(input string tag, input int budget);
        int c = 0;
        while ((exp_d.size() != 0 || pending_bytes() != 0) && c < budget) begin
            tick();
            c++;
        end
        repeat (3) tick();
        check({tag, "_drained"}, 64'(exp_d.size() + pending_bytes()), 64'd0);
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
        check({tag, "_trunc"}, 64'(trunc_seen), 64'(exp_trunc));
    endtask

    task automatic flush_model();
        for (int l = 0; l < NL; l++) begin
            lane_bytes[l].delete(); lane_lastf[l].delete();
            model_bytes[l].delete(); model_lens[l].delete();
        end
        exp_d.delete(); exp_k.delete(); exp_l.delete(); exp_order.delete();
        rr_model = 0; exp_pkts = 0; exp_trunc = 0; trunc_seen = 0; prev_stall = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, 64'(tvalid), 64'd0);
        check({tag, "_tdata"}, tdata, 64'd0);
        check({tag, "_tkeep"}, 64'(tkeep), 64'd0);
        check({tag, "_tlast"}, 64'(tlast), 64'd0);
        check({tag, "_trunc"}, 64'(trunc), 64'd0);
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'd0);
        check({tag, "_lane_tready"}, 64'(lane_tready), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        lane_tvalid = '0; lane_tlast = '0; tready = 1'b0;
        flush_model();
        repeat (2) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // single 8-byte packet on lane 2
        add_packet(2, 8, 1, 1);
        model_schedule();
        run_until_done("t1", 200);
        check("t1_word", last_d, 64'h0807_0605_0403_0201);

        // 13-byte packet on lane 0, valid gaps
        gap_mode = 1;
        add_packet(0, 13, 0, 1);
        model_schedule();
        run_until_done("t2", 300);
        gap_mode = 0;

        // three lanes with 1-byte packets, lane 0 twice: order 0,3,7,0
        do_reset();
        add_packet(0, 1, 0, 1);
        add_packet(0, 1, 0, 1);
        add_packet(3, 1, 0, 1);
        add_packet(7, 1, 0, 1);
        model_schedule();
        run_until_done("t3", 200);

        // backpressure: 24-byte packet, tready low for 20 cycles
        add_packet(5, 24, 0, 1);
        model_schedule();
        acc_cnt = 0;
        tready_mode = 2;
        repeat (20) tick();
        check("t4_bytes_taken", 64'(acc_cnt), 64'd15);
        check("t4_lane_tready", 64'(lane_tready), 64'd0);
        check("t4_tvalid_held", 64'(tvalid), 64'd1);
        tready_mode = 0;
        run_until_done("t4", 300);

        // truncation: exact limit, limit+10, then a short packet
        add_packet(1, MAXB, 0, 1);
        add_packet(1, MAXB + 10, 0, 1);
        add_packet(1, 5, 0, 1);
        model_schedule();
        tready_mode = 1;
        run_until_done("t5", 2000);

        // randomized multi-lane rounds with random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < NL; l++) begin
                int np = $urandom_range(0, 3);
                for (int p = 0; p < np; p++) add_packet(l, $urandom_range(1, 90), 0, 1);
            end
            model_schedule();
            run_until_done("rand", 20000);
        end
        tready_mode = 0;

        // reset in the middle of a lane 4 packet
        add_packet(4, 20, 0, 0);
        repeat (6) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_async");
        flush_model();
        lane_tvalid = '0; lane_tlast = '0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        add_packet(4, 3, 0, 1);
        add_packet(0, 10, 0, 1);
        model_schedule();
        check("t6_first_lane", 64'(exp_order[0]), 64'd0);
        run_until_done("t6", 300);

        check("ready_onehot", 64'(onehot_viol), 64'd0);
        check("stall_stable", 64'(stall_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
